// File: rtl/nibble_serial_adder.sv
// Digit-serial adder: latches two operands, then adds one 4-bit digit per
// clock (least significant first) and holds the result until it is taken.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_sum,
  output logic                   out_cout,
  output logic                   busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic          r_carry;
  logic          r_cout;
  logic [IW-1:0] r_idx;

  logic          w_accept;
  logic          w_last;
  logic [3:0]    w_a_dig;
  logic [3:0]    w_b_dig;
  logic [4:0]    w_res;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_idx >= IW'(NIBBLES - 1));
  assign w_a_dig  = r_a[int'(r_idx) * 4 +: 4];
  assign w_b_dig  = r_b[int'(r_idx) * 4 +: 4];
  assign w_res    = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {4'd0, r_carry};

  assign out_sum  = r_sum;
  assign out_cout = r_cout;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; the unused encoding falls back to IDLE
  always_comb begin
    w_state_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_state_next = w_accept ? S_ADD : S_IDLE;
      S_ADD:   w_state_next = w_last ? S_DONE : S_ADD;
      S_DONE:  w_state_next = out_ready ? S_IDLE : S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Handshake outputs; in_ready is also gated by reset so it reads 0 during reset
  always_comb begin
    in_ready  = rst_n && (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    busy      = (r_state == S_ADD) || (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= in_cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
          end
        end
        S_ADD: begin
          r_sum[int'(r_idx) * 4 +: 4] <= w_res[3:0];
          r_carry                      <= w_res[4];
          // Index parks on the top digit so it never leaves range
          if (w_last) begin
            r_cout <= w_res[4];
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder with NIBBLES=4; every step is checked
// against hand-computed values sampled on the falling clock edge.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c);
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    $display("accept a=0x%04h b=0x%04h cin=%0d", a, b, c);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_cout", out_cout, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);

    // Basic add, digit-by-digit
    start_op(16'h1234, 16'h4321, 1'b0);
    chk("basic_busy", busy, 1);
    chk("basic_in_ready", in_ready, 0);
    chk("basic_sum0", out_sum, 16'h0000);
    tick(); chk("basic_sum1", out_sum, 16'h0005); chk("basic_v1", out_valid, 0);
    tick(); chk("basic_sum2", out_sum, 16'h0055); chk("basic_v2", out_valid, 0);
    tick(); chk("basic_sum3", out_sum, 16'h0555); chk("basic_v3", out_valid, 0);
    tick(); chk("basic_sum4", out_sum, 16'h5555); chk("basic_v4", out_valid, 1);
    chk("basic_cout", out_cout, 0);
    $display("result sum=0x%04h cout=%0d", out_sum, out_cout);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("basic_valid_drop", out_valid, 0);
    chk("basic_idle_ready", in_ready, 1);

    // Full ripple with carry-in, then backpressure in DONE
    start_op(16'hFFFF, 16'h0000, 1'b1);
    repeat (4) tick();
    chk("ripple_valid", out_valid, 1);
    chk("ripple_sum", out_sum, 16'h0000);
    chk("ripple_cout", out_cout, 1);
    $display("result sum=0x%04h cout=%0d", out_sum, out_cout);
    for (int k = 0; k < 5; k++) begin
      in_valid = ~in_valid;
      in_a = 16'h1111 * 16'(k + 1);
      in_b = 16'h0F0F ^ 16'(k);
      in_cin = ~in_cin;
      tick();
      chk("bp_sum", out_sum, 16'h0000);
      chk("bp_cout", out_cout, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_busy", busy, 0);

    // Top-digit carry only
    start_op(16'h8000, 16'h8000, 1'b0);
    repeat (4) tick();
    chk("msb_valid", out_valid, 1);
    chk("msb_sum", out_sum, 16'h0000);
    chk("msb_cout", out_cout, 1);
    $display("result sum=0x%04h cout=%0d", out_sum, out_cout);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset mid-cycle while holding a nonzero result
    start_op(16'h7000, 16'h9001, 1'b1);
    repeat (4) tick();
    chk("pre_arst_sum", out_sum, 16'h0002);
    chk("pre_arst_cout", out_cout, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_cout", out_cout, 0);
    chk("arst_sum", out_sum, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_release_ready", in_ready, 1);

    // Abort after two ADD cycles
    start_op(16'h1234, 16'h4321, 1'b0);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("abort_no_valid", out_valid, 0);
    end
    start_op(16'h00FF, 16'h0001, 1'b0);
    repeat (3) tick();
    chk("post_abort_v3", out_valid, 0);
    tick();
    chk("post_abort_valid", out_valid, 1);
    chk("post_abort_sum", out_sum, 16'h0100);
    chk("post_abort_cout", out_cout, 0);
    $display("result sum=0x%04h cout=%0d", out_sum, out_cout);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Back-to-back with in_valid and out_ready both held high
    out_ready = 1'b1;
    in_a = 16'h0001; in_b = 16'h0001; in_cin = 1'b0; in_valid = 1'b1;
    tick();
    $display("accept a=0x0001 b=0x0001 cin=0");
    in_a = 16'hABCD; in_b = 16'h1111;
    chk("b2b_busy1", busy, 1);
    repeat (3) tick();
    chk("b2b_v1_early", out_valid, 0);
    tick();
    chk("b2b_v1", out_valid, 1);
    chk("b2b_sum1", out_sum, 16'h0002);
    chk("b2b_cout1", out_cout, 0);
    $display("result sum=0x%04h cout=%0d", out_sum, out_cout);
    tick();
    chk("b2b_gap_valid", out_valid, 0);
    chk("b2b_gap_busy", busy, 0);
    chk("b2b_gap_ready", in_ready, 1);
    tick();
    $display("accept a=0xabcd b=0x1111 cin=0");
    in_valid = 1'b0;
    chk("b2b_accept2", busy, 1);
    repeat (3) tick();
    chk("b2b_v2_early", out_valid, 0);
    tick();
    chk("b2b_v2", out_valid, 1);
    chk("b2b_sum2", out_sum, 16'hBCDE);
    chk("b2b_cout2", out_cout, 0);
    $display("result sum=0x%04h cout=%0d", out_sum, out_cout);
    tick();
    chk("b2b_final_valid", out_valid, 0);
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001: Parameter NIBBLES, default 4, sets the number of 4-bit digits per operand; W = 4*NIBBLES; legal range 2..8.
REQ-002: The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003: clk  input  1  rising-edge clock for all state.
REQ-004: rst_n  input  1  asynchronous active-low reset.
REQ-005: in_valid  input  1  operand set presented.
REQ-006: in_ready  output  1  block can accept operands.
REQ-007: in_a  input  W  operand A.
REQ-008: in_b  input  W  operand B.
REQ-009: in_cin  input  1  carry-in for digit 0.
REQ-010: out_valid  output  1  result available.
REQ-011: out_ready  input  1  consumer takes the result.
REQ-012: out_sum  output  W  registered sum.
REQ-013: out_cout  output  1  carry-out from the top digit.
REQ-014: busy  output  1  high in ADD or DONE.

Function
REQ-015: The FSM SHALL have three states: IDLE, ADD and DONE.
REQ-016: IDLE behaviour: in_ready=1, out_valid=0.
- Accept on the rising edge with in_valid&&in_ready.
- On accept, latch in_a, in_b and in_cin into internal registers, clear digit index to 0, clear out_sum, and move to ADD.
REQ-017: ADD behaviour, one 4-bit digit per cycle:
- {c,s} = A[4i+3:4i] + B[4i+3:4i] + carry, computed as a 5-bit result.
- Write s into out_sum[4i+3:4i] and c into the carry register.
- Increment i.
- After digit NIBBLES-1, move to DONE with out_cout = final c.
REQ-018: Latency: out_valid SHALL rise exactly NIBBLES clock edges after the accept edge (4 for the default).
REQ-019: DONE behaviour: out_valid=1; out_sum and out_cout held stable.
- On the edge with out_ready=1, return to IDLE.
- out_valid deasserts the following cycle.
REQ-020: in_ready SHALL be 0 in ADD and DONE.
- in_valid and operand changes are ignored there.
- Operands are sampled only at the accept edge.
REQ-021: The block SHALL NOT accept in the same cycle as the output handshake; the earliest next accept is the cycle after the DONE->IDLE edge.
REQ-022: out_ready in IDLE or ADD SHALL have no effect.
REQ-023: Overflow wrap-around: the sum is modulo 2^W and the overflow bit is reported only on out_cout.
- Example: 0xFFFF+0x0001+0 -> sum 0x0000, cout 1.
REQ-024: The digit index SHALL never exceed NIBBLES-1.
- Out-of-range state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-025: With rst_n low, the block SHALL immediately (without a clock) reset:
- state IDLE;
- out_sum 0, out_cout 0, out_valid 0, busy 0;
- carry and index registers 0.
REQ-026: in_ready SHALL be 0 while rst_n is low and 1 from the first cycle after release.
REQ-027: Reset during ADD or DONE SHALL discard the operation.
- No partial result is presented.
- The first post-reset operation SHALL be unaffected.

Verification
REQ-028: Reset: assert rst_n=0 mid-cycle -> all outputs 0 with no clock edge; after release, in_ready=1.
REQ-029: Basic add: 0x1234 + 0x4321, cin 0 -> out_sum 0x5555, cout 0, out_valid exactly 4 edges after accept.
- Check each digit is written in order on edges 1..4.
REQ-030: Full ripple: 0xFFFF + 0x0000, cin 1 -> out_sum 0x0000, cout 1.
- Also 0x8000 + 0x8000, cin 0 -> 0x0000, cout 1.
REQ-031: Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands -> sum and cout stable, in_ready=0, nothing accepted.
- Release -> IDLE the next cycle.
REQ-032: Abort: pulse rst_n low after 2 ADD cycles -> out_valid never asserts.
- Next op 0x00FF + 0x0001 -> 0x0100, cout 0.
REQ-033: Back-to-back: keep in_valid high with out_ready=1 for two ops (0x0001+0x0001, then 0xABCD+0x1111) -> results 0x0002 and 0xBCDE.
- The second accept occurs one cycle after the first output handshake.
- Period is 6 cycles per op.
